pow_unit: RTL
=============

Name: pow_unit

Overview:
- Parametrised successor to the fixed cube block: computes y = x^e for a runtime exponent e.
- Operand width, exponent width and result width are generics.
- Self-contained iterative shift-add multiplier, one partial product per cycle; no external multiplier instance.
- Sits on the same single-clock datapath as the cube block; single-shot start/busy/valid handshake.

Parameters:
W, 8, operand width of x_bi.
EXP_W, 3, exponent width; e in 0..2^EXP_W-1.
OUT_W, 24, result width; must satisfy OUT_W >= W. Higher bits are truncated and flagged.

Ports:
clk_i  in  1  clock, all logic on rising edge.
rst_ni  in  1  synchronous reset, active-low.
x_bi  in  W  base operand, unsigned.
e_bi  in  EXP_W  exponent, unsigned.
start_i  in  1  request; sampled only in IDLE.
busy_o  out  1  high while a computation is in progress.
valid_o  out  1  one-cycle pulse when y_bo/ovf_o are updated.
y_bo  out  OUT_W  result x^e mod 2^OUT_W; holds until the next result.
ovf_o  out  1  set if any intermediate or final product exceeded OUT_W bits; updated with valid_o.

Behaviour:
- Reset (rst_ni=0 at a clock edge):
  - y_bo=0, ovf_o=0, valid_o=0, busy_o=0; state=IDLE; internal registers cleared.
  - Reset mid-operation aborts the computation; no valid_o pulse follows.
- States: IDLE, MUL, DONE.
- IDLE + start_i=1 at edge k: latch x, e.
  - e==0: go to DONE with res=1, ovf=0.
  - e==1 or x==0 (e>0): go to DONE with res=x (zero-extended), ovf=0.
  - Otherwise: acc=x, cnt=e-1, bit index i=0, prod=0, ovf_acc=0; go to MUL.
- MUL, one cycle per bit i = 0..W-1:
  - If x[i]: prod += acc << i. prod is OUT_W+W bits wide.
  - At i==W-1: acc <= prod[OUT_W-1:0]; ovf_acc |= |prod[OUT_W+W-1:OUT_W]; prod cleared; cnt--.
  - When cnt reaches 0 → DONE with res=acc (that final acc); else restart at i=0.
  - Each multiply takes exactly W cycles.
- DONE (one cycle): y_bo <= res, ovf_o <= ovf_acc, valid_o=1, busy_o=0; next state IDLE.
  - valid_o is registered: high in the cycle after DONE is entered, for one cycle. y_bo is valid from that same cycle.
- busy_o = 1 in MUL and in the DONE-entry path, i.e. from edge k+1 until the edge where valid_o rises. busy_o=0 while valid_o=1.
- Latency (acceptance edge k to valid_o high):
  - Shortcut cases: 2 cycles.
  - General case: (e-1)*W + 2 cycles.
  - W=8, e=3: 18 cycles.
- start_i while busy_o=1: ignored; x_bi/e_bi changes are ignored because operands are latched.
- start_i in the cycle valid_o=1: accepted, since state is IDLE.
- Truncation: y_bo always equals the true x^e mod 2^OUT_W. ovf_o is sticky across the multiplies of one computation and cleared at each new acceptance.

Test Plan:
1. Reset released, x=5, e=3, one-cycle start → busy_o high; valid_o at cycle 18 after acceptance; y_bo=125, ovf_o=0.
2. x=255, e=3 → y_bo=0xFD02FF (16581375), ovf_o=0. Then x=255, e=4 → y_bo=0x05FC01, ovf_o=1.
3. Shortcuts: x=77, e=0 → y_bo=1; x=0, e=5 → y_bo=0; x=200, e=1 → y_bo=200. Each has valid_o 2 cycles after start, ovf_o=0.
4. Start x=3, e=7; pulse start_i with x=9 mid-run and change x_bi → ignored; y_bo=2187, latency 6*8+2=50 cycles.
5. Start x=7, e=5; assert rst_ni=0 for one cycle at cycle 10 → busy_o=0, y_bo=0, no valid_o; a fresh start with x=2, e=4 gives y_bo=16.
6. Back-to-back: start asserted in the valid_o cycle of x=2, e=2 (y_bo=4) with x=3, e=2 → accepted; y_bo=9 after 10 more cycles.

Source files
------------

// File: rtl/pow_unit_if.sv
// Operand/result bundle for pow_unit: operands and start in, busy/valid/result out.
// Parameters must match the pow_unit instance the bundle is attached to.
interface pow_unit_if #(
  parameter int W     = 8,
  parameter int EXP_W = 3,
  parameter int OUT_W = 24
);
  logic [W-1:0]     x_bi;
  logic [EXP_W-1:0] e_bi;
  logic             start_i;
  logic             busy_o;
  logic             valid_o;
  logic [OUT_W-1:0] y_bo;
  logic             ovf_o;

  modport master (
    output x_bi, e_bi, start_i,
    input  busy_o, valid_o, y_bo, ovf_o
  );

  modport slave (
    input  x_bi, e_bi, start_i,
    output busy_o, valid_o, y_bo, ovf_o
  );
endinterface

// File: rtl/pow_unit.sv
// Iterative y = x^e (mod 2^OUT_W) using a shift-add multiplier that retires one
// partial product per cycle; ovf_o flags any truncated bits along the way.
module pow_unit #(
  parameter int W     = 8,
  parameter int EXP_W = 3,
  parameter int OUT_W = 24
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  pow_unit_if.slave  bus
);

  localparam int PW = OUT_W + W;
  localparam int IW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  state_t           state_reg, state_next;
  logic [W-1:0]     x_reg, x_next;
  logic [EXP_W-1:0] cnt_reg, cnt_next;
  logic [IW-1:0]    bit_reg, bit_next;
  logic [OUT_W-1:0] acc_reg, acc_next;
  logic [PW-1:0]    prod_reg, prod_next;
  logic             ovf_acc_reg, ovf_acc_next;
  logic [OUT_W-1:0] y_reg, y_next;
  logic             ovf_reg, ovf_next;
  logic             valid_reg, valid_next;

  logic [PW-1:0]    acc_ext;
  logic [PW-1:0]    pp_tab [W];
  logic [PW-1:0]    prod_sum;
  logic             last_bit;

  assign acc_ext = PW'(acc_reg);

  // Partial product for every bit position; the current bit index picks one.
  for (genvar gi = 0; gi < W; gi++) begin : g_pp
    assign pp_tab[gi] = x_reg[gi] ? (acc_ext << gi) : '0;
  end

  assign prod_sum = prod_reg + pp_tab[bit_reg];
  assign last_bit = (bit_reg == IW'(W - 1));

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_reg   <= IDLE;
      x_reg       <= '0;
      cnt_reg     <= '0;
      bit_reg     <= '0;
      acc_reg     <= '0;
      prod_reg    <= '0;
      ovf_acc_reg <= 1'b0;
      y_reg       <= '0;
      ovf_reg     <= 1'b0;
      valid_reg   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      x_reg       <= x_next;
      cnt_reg     <= cnt_next;
      bit_reg     <= bit_next;
      acc_reg     <= acc_next;
      prod_reg    <= prod_next;
      ovf_acc_reg <= ovf_acc_next;
      y_reg       <= y_next;
      ovf_reg     <= ovf_next;
      valid_reg   <= valid_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    x_next       = x_reg;
    cnt_next     = cnt_reg;
    bit_next     = bit_reg;
    acc_next     = acc_reg;
    prod_next    = prod_reg;
    ovf_acc_next = ovf_acc_reg;
    y_next       = y_reg;
    ovf_next     = ovf_reg;
    valid_next   = 1'b0;

    unique case (state_reg)
      IDLE: begin
        if (bus.start_i) begin
          x_next       = bus.x_bi;
          cnt_next     = bus.e_bi - EXP_W'(1);
          bit_next     = '0;
          prod_next    = '0;
          ovf_acc_next = 1'b0;
          acc_next     = OUT_W'(bus.x_bi);
          // x^0, x^1 and 0^e need no multiply at all.
          if (bus.e_bi == '0) begin
            acc_next   = OUT_W'(1);
            state_next = DONE;
          end else if (bus.e_bi == EXP_W'(1) || bus.x_bi == '0) begin
            state_next = DONE;
          end else begin
            state_next = MUL;
          end
        end
      end

      MUL: begin
        prod_next = prod_sum;
        bit_next  = bit_reg + IW'(1);
        if (last_bit) begin
          acc_next     = prod_sum[OUT_W-1:0];
          ovf_acc_next = ovf_acc_reg | (|prod_sum[PW-1:OUT_W]);
          prod_next    = '0;
          bit_next     = '0;
          cnt_next     = cnt_reg - EXP_W'(1);
          if (cnt_reg == EXP_W'(1)) begin
            state_next = DONE;
          end
        end
      end

      DONE: begin
        y_next     = acc_reg;
        ovf_next   = ovf_acc_reg;
        valid_next = 1'b1;
        state_next = IDLE;
      end

      default: state_next = IDLE;
    endcase
  end

  assign bus.busy_o  = (state_reg != IDLE);
  assign bus.valid_o = valid_reg;
  assign bus.y_bo    = y_reg;
  assign bus.ovf_o   = ovf_reg;

endmodule
